// File: rtl/fpu_arb_pkg.sv
// Shared encodings for the two-port FPU request arbiter: op codes, FSM states, default latencies.
package fpu_arb_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_CMP = 3'd4
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int DEF_LAT_ADDSUB = 2;
    localparam int DEF_LAT_MUL    = 3;
    localparam int DEF_LAT_DIV    = 6;
    localparam int DEF_LAT_CMP    = 1;

    // Wide enough for any realistic ALU latency.
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } fpu_req_t;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last-served pointer resets so requester 0 wins first contention.
// Latency: combinational grant, pointer updates on the accepting edge.
// Backpressure: grant is only a proposal; pointer moves only when advance is asserted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Arbitrates two requesters onto one external FPU ALU and returns tagged responses.
// Latency: response valid LAT+1 cycles after the accept cycle (1 cycle for illegal ops).
// Backpressure: one op in flight; requesters see ready only in IDLE, response held until rsp_ready.
module fpu_req_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned LAT_ADDSUB = DEF_LAT_ADDSUB,
    parameter int unsigned LAT_MUL    = DEF_LAT_MUL,
    parameter int unsigned LAT_DIV    = DEF_LAT_DIV,
    parameter int unsigned LAT_CMP    = DEF_LAT_CMP
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [2:0]  req_op_0,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,

    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [2:0]  req_op_1,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,

    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_equal,
    input  logic        alu_greater,
    input  logic        alu_lesser,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_flags,
    output logic        rsp_err,

    output logic        busy
);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       grant;
    logic             acc;
    fpu_req_t         sel;

    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB: return CNT_W'(LAT_ADDSUB);
            OP_MUL:         return CNT_W'(LAT_MUL);
            OP_DIV:         return CNT_W'(LAT_DIV);
            default:        return CNT_W'(LAT_CMP);
        endcase
    endfunction

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({req_valid_1, req_valid_0}),
        .advance (acc),
        .grant   (grant)
    );

    assign sel = grant[1] ? '{op: req_op_1, a: req_a_1, b: req_b_1}
                          : '{op: req_op_0, a: req_a_0, b: req_b_0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b0;
        acc         = 1'b0;
        case (state_q)
            IDLE: begin
                // Reset is asynchronous, so ready must drop with it rather than a cycle later.
                req_ready_0 = grant[0] & ~rst;
                req_ready_1 = grant[1] & ~rst;
                acc         = (req_valid_0 & req_ready_0) | (req_valid_1 & req_ready_1);
                if (acc) begin
                    state_d = op_is_valid(sel.op) ? BUSY : RESP;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else if (acc) begin
            rsp_id <= grant[1];
            if (op_is_valid(sel.op)) begin
                alu_op <= sel.op;
                alu_a  <= sel.a;
                alu_b  <= sel.b;
                cnt_q  <= lat_of(sel.op);
            end else begin
                // Illegal op never reaches the ALU; alu_* keep the previous operands.
                rsp_err   <= 1'b1;
                rsp_data  <= '0;
                rsp_flags <= '0;
            end
        end else if (state_q == BUSY) begin
            if (cnt_q == CNT_W'(1)) begin
                rsp_data  <= alu_out;
                rsp_flags <= {alu_equal, alu_greater, alu_lesser};
                rsp_err   <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter with a table-driven ALU stand-in.
module tb_fpu_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic        req_ready_0, req_ready_1;
    logic [2:0]  req_op_0 = '0, req_op_1 = '0;
    logic [31:0] req_a_0 = '0, req_b_0 = '0, req_a_1 = '0, req_b_1 = '0;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_equal, alu_greater, alu_lesser;
    logic        rsp_valid, rsp_id, rsp_err, busy;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_req_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .alu_equal(alu_equal), .alu_greater(alu_greater), .alu_lesser(alu_lesser),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy)
    );

    // ALU stand-in: known results for the directed vectors, integer compare for flags
    // (valid ordering for the positive floats used here).
    always_comb begin
        alu_out = alu_a ^ alu_b;
        case (alu_op)
            3'd0: if (alu_a == 32'h41FC0000 && alu_b == 32'h3F480000) alu_out = 32'h42012000;
            3'd1: if (alu_a == 32'h40400000 && alu_b == 32'h3F800000) alu_out = 32'h40000000;
            3'd2: if (alu_a == 32'h40000000 && alu_b == 32'h40400000) alu_out = 32'h40C00000;
            3'd4: alu_out = 32'h0;
            default: ;
        endcase
        alu_equal   = (alu_a == alu_b);
        alu_greater = (alu_a > alu_b);
        alu_lesser  = (alu_a < alu_b);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_outputs_zero(input string tag);
        chk(tag, {req_ready_0, req_ready_1, busy, rsp_valid, rsp_id, rsp_data, rsp_flags,
                  rsp_err, alu_op, alu_a, alu_b}, '0);
    endtask

    // One request from a single requester, response latency measured in cycles after
    // the accept cycle; hold = cycles rsp_ready stays low once the response is up.
    task automatic do_req(input string tag, input logic id, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_data, input logic [2:0] exp_flags,
                          input logic exp_err, input int hold, input logic probe);
        int lat;
        @(negedge clk);
        if (id) begin
            req_valid_1 = 1'b1; req_op_1 = op; req_a_1 = a; req_b_1 = b;
        end else begin
            req_valid_0 = 1'b1; req_op_0 = op; req_a_0 = a; req_b_0 = b;
        end
        #1;
        chk({tag, "_ready"}, {req_ready_1, req_ready_0}, id ? 2'b10 : 2'b01);
        @(negedge clk);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rsp"}, {rsp_id, rsp_data, rsp_flags, rsp_err}, {id, exp_data, exp_flags, exp_err});
        chk({tag, "_no_ready_in_resp"}, {req_ready_1, req_ready_0}, 2'b00);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err},
                {1'b1, id, exp_data, exp_flags, exp_err});
        end
        rsp_ready = 1'b1;
        if (probe) begin
            req_valid_1 = 1'b1;
            #1;
            chk({tag, "_no_accept_on_handshake"}, {req_ready_1, req_ready_0}, 2'b00);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk({tag, "_idle_after"}, {rsp_valid, busy}, 2'b00);
        if (probe) begin
            chk({tag, "_accept_next_idle"}, req_ready_1, 1'b1);
            req_valid_1 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;

        // Reset: outputs held at zero even with a request pending.
        req_valid_0 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        all_outputs_zero("reset_outputs");
        rst = 1'b0;
        req_valid_0 = 1'b0;

        do_req("add", 1'b0, 3'd0, 32'h41FC0000, 32'h3F480000, 3, 32'h42012000, 3'b010, 1'b0, 0, 1'b0);
        do_req("mul", 1'b1, 3'd2, 32'h40000000, 32'h40400000, 4, 32'h40C00000, 3'b001, 1'b0, 0, 1'b0);
        do_req("cmp", 1'b0, 3'd4, 32'h40E00000, 32'h40600000, 2, 32'h00000000, 3'b010, 1'b0, 0, 1'b0);
        do_req("badop", 1'b1, 3'd6, 32'h12345678, 32'h9ABCDEF0, 1, 32'h0, 3'b000, 1'b1, 0, 1'b0);
        chk("badop_alu_unchanged", {alu_op, alu_a, alu_b}, {3'd4, 32'h40E00000, 32'h40600000});
        do_req("bp_sub", 1'b0, 3'd1, 32'h40400000, 32'h3F800000, 3, 32'h40000000, 3'b010, 1'b0, 5, 1'b1);

        // Reset in the middle of a divide: everything clears and no response follows.
        @(negedge clk);
        req_valid_1 = 1'b1; req_op_1 = 3'd3; req_a_1 = 32'h41200000; req_b_1 = 32'h40000000;
        @(negedge clk);
        req_valid_1 = 1'b0;
        @(negedge clk);
        #1;
        chk("div_busy", {busy, rsp_valid}, 2'b10);
        rst = 1'b1;
        #1;
        all_outputs_zero("reset_mid_busy");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("no_rsp_after_reset", seen, 0);

        // Contention straight after reset: 0 first, then strict alternation.
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid_0 = 1'b1; req_op_0 = 3'd4; req_a_0 = 32'h1; req_b_0 = 32'h2;
        req_valid_1 = 1'b1; req_op_1 = 3'd0; req_a_1 = 32'h3; req_b_1 = 32'h4;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(req_ready_0 || req_ready_1) && n < 30) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("rr_grant", {req_ready_1, req_ready_0}, (g % 2 == 1) ? 2'b10 : 2'b01);
            @(negedge clk);
            #1;
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        repeat (10) @(negedge clk);
        rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_req_arbiter.md
FPU_REQ_ARBITER -- requirements
Module: fpu_req_arbiter

Interface
REQ-001 The block SHALL have parameter LAT_ADDSUB, default 2, meaning ALU cycles for op 0/1.
REQ-002 The block SHALL have parameter LAT_MUL, default 3, meaning ALU cycles for op 2.
REQ-003 The block SHALL have parameter LAT_DIV, default 6, meaning ALU cycles for op 3.
REQ-004 The block SHALL have parameter LAT_CMP, default 1, meaning ALU cycles for op 4; every LAT_* SHALL be at least 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-006 Per requester i in {0,1}, the block SHALL have: req_valid_i in 1; req_ready_i out 1; req_op_i in 3 (0 add, 1 sub, 2 mul, 3 div, 4 compare); req_a_i in 32; req_b_i in 32.
REQ-007 The ALU side SHALL be: alu_op out 3; alu_a out 32; alu_b out 32; alu_out in 32; alu_equal in 1; alu_greater in 1; alu_lesser in 1.
REQ-008 The response side SHALL be: rsp_valid out 1; rsp_ready in 1; rsp_id out 1 (requester index); rsp_data out 32; rsp_flags out 3 {equal,greater,lesser}; rsp_err out 1.
REQ-009 The block SHALL have busy out 1, high in every state except IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-011 In IDLE, req_ready_i SHALL be high only for the granted requester; at most one req_ready SHALL be high, and req_ready SHALL be low in BUSY and RESP.
REQ-012 Grant SHALL be round-robin: when only one requester is valid it wins; when both are valid, the requester not served last wins.
REQ-013 On acceptance at edge T (valid & ready), the block SHALL register op/a/b onto alu_op/alu_a/alu_b, load the counter with the op's LAT, and enter BUSY.
REQ-014 alu_op/alu_a/alu_b SHALL hold stable from T+1 until the next acceptance.
REQ-015 BUSY SHALL last exactly LAT cycles; on its last edge the block SHALL capture alu_out and flags into rsp_data/rsp_flags and enter RESP, so rsp_valid is high from cycle T+LAT+1.
REQ-016 In RESP, rsp_valid SHALL be high and rsp_id/rsp_data/rsp_flags/rsp_err SHALL be stable until rsp_ready is sampled high; the block SHALL then return to IDLE.
REQ-017 A new request SHALL NOT be accepted in the cycle of the response handshake; the earliest next acceptance is the following IDLE cycle.
REQ-018 An op code of 5-7 SHALL be accepted, SHALL NOT change alu_* outputs, and SHALL go directly to RESP next cycle with rsp_err=1, rsp_data=0, rsp_flags=0.
REQ-019 For ops 0-3, rsp_flags SHALL be the captured ALU flags unaltered; rsp_err SHALL be 0 for valid ops.
REQ-020 rsp_valid SHALL never be high in the same cycle as any req_ready.

Reset
REQ-021 While rst is high, the FSM SHALL be IDLE and all outputs SHALL be 0, including req_ready_*, busy, rsp_*, and alu_*.
REQ-022 Reset SHALL set the round-robin pointer so that requester 0 wins the first contention.
REQ-023 Reset asserted mid-BUSY or mid-RESP SHALL discard the in-flight operation without producing any response.

Structure
REQ-024 Package fpu_arb_pkg SHALL hold the op encodings, FSM state encoding, and default latency constants.
REQ-025 Two-way round-robin grant logic SHALL be the sub-module rr_arb2; the ALU SHALL stay external and be connected at the top level.

Verification
REQ-026 Bench SHALL cover this add case: req0 op0, A=0x41FC0000, B=0x3F480000 -> rsp_data=0x42012000, rsp_id=0, rsp_valid at T+3.
REQ-027 Bench SHALL cover this mul case: req1 op2, A=0x40000000, B=0x40400000 -> rsp_data=0x40C00000, rsp_id=1, rsp_valid at T+4.
REQ-028 Bench SHALL cover this compare case: op4, A=0x40E00000, B=0x40600000 -> rsp_flags=3'b010, rsp_valid at T+2.
REQ-029 Bench SHALL cover contention: both valid continuously -> grants alternate 0,1,0,1 and no request is starved.
REQ-030 Bench SHALL cover an invalid op: op=6 -> rsp_err=1, rsp_data=0 one cycle after acceptance, and alu_* unchanged.
REQ-031 Bench SHALL cover backpressure and reset: rsp_ready low for 5 cycles keeps rsp_* stable; rst pulsed mid-BUSY on op3 -> all outputs 0 and no response afterwards.
